// File: rtl/max_popcount_pkg.sv
// Shared state encoding and width helpers for the max-popcount selector.
package max_popcount_pkg;

  typedef enum logic [1:0] {ACC, CMP, OUT} state_t;

  function automatic int unsigned cnt_width(input int unsigned wdt, input int unsigned len);
    return $clog2(wdt * len + 1);
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/popcount.sv
// Combinational population count of one Width-bit word.
module popcount #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0]           in_i,
  output logic [$clog2(Width+1)-1:0] out_o
);

  localparam int unsigned OutW = $clog2(Width + 1);

  always_comb begin
    out_o = '0;
    for (int i = 0; i < Width; i++) begin
      out_o = out_o + OutW'(in_i[i]);
    end
  end

endmodule

// File: rtl/max_popcount_sel.sv
// Per-frame popcount accumulation over InCnt channels, reporting the densest channel,
// its total and a tie flag over a valid/ready result interface.
module max_popcount_sel
  import max_popcount_pkg::*;
#(
  parameter  int unsigned InCnt  = 4,
  parameter  int unsigned InWdt  = 8,
  parameter  int unsigned AccLen = 1,
  localparam int unsigned CntW   = cnt_width(InWdt, AccLen),
  localparam int unsigned IdxW   = idx_width(InCnt)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [InCnt*InWdt-1:0] data_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [IdxW-1:0]        idx_o,
  output logic [CntW-1:0]        cnt_o,
  output logic                   tie_o
);

  localparam int unsigned PcW   = $clog2(InWdt + 1);
  localparam int unsigned BeatW = $clog2(AccLen + 1);

  state_t           r_state;
  logic [BeatW-1:0] r_beat;
  logic [CntW-1:0]  r_acc [InCnt];
  logic [IdxW-1:0]  r_idx;
  logic [CntW-1:0]  r_cnt;
  logic             r_tie;

  logic [PcW-1:0]   w_pc [InCnt];
  logic [IdxW-1:0]  w_max_idx;
  logic [CntW-1:0]  w_max_cnt;
  logic             w_seen;
  logic             w_tie;
  logic             w_last;

  for (genvar g = 0; g < InCnt; g++) begin : g_pc
    popcount #(
      .Width(InWdt)
    ) u_popcount (
      .in_i (data_i[g*InWdt +: InWdt]),
      .out_o(w_pc[g])
    );
  end

  // Strict '>' from index 0 upward: the lowest index wins ties.
  always_comb begin
    w_max_idx = '0;
    w_max_cnt = r_acc[0];
    for (int k = 1; k < InCnt; k++) begin
      if (r_acc[k] > w_max_cnt) begin
        w_max_cnt = r_acc[k];
        w_max_idx = IdxW'(k);
      end
    end
    w_seen = 1'b0;
    w_tie  = 1'b0;
    for (int k = 0; k < InCnt; k++) begin
      if (r_acc[k] == w_max_cnt) begin
        if (w_seen) w_tie = 1'b1;
        w_seen = 1'b1;
      end
    end
  end

  assign w_last  = (r_beat == BeatW'(AccLen - 1));
  assign ready_o = (r_state == ACC);
  assign valid_o = (r_state == OUT);
  assign idx_o   = r_idx;
  assign cnt_o   = r_cnt;
  assign tie_o   = r_tie;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ACC;
      r_beat  <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_tie   <= 1'b0;
      for (int k = 0; k < InCnt; k++) r_acc[k] <= '0;
    end else begin
      case (r_state)
        ACC: begin
          if (valid_i) begin
            for (int k = 0; k < InCnt; k++) r_acc[k] <= r_acc[k] + CntW'(w_pc[k]);
            r_beat <= r_beat + 1'b1;
            if (w_last) r_state <= CMP;
          end
        end
        CMP: begin
          r_idx   <= w_max_idx;
          r_cnt   <= w_max_cnt;
          r_tie   <= w_tie;
          r_state <= OUT;
        end
        OUT: begin
          if (ready_i) begin
            for (int k = 0; k < InCnt; k++) r_acc[k] <= '0;
            r_beat  <= '0;
            r_state <= ACC;
          end
        end
        default: r_state <= ACC;
      endcase
    end
  end

endmodule
